// File: rtl/flappy_pkg.sv
// Shared types and screen constants for the flappy-bird game blocks.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_DEAD  = 2'd3
    } bird_state_t;

    localparam int FRAC_W   = 4;
    localparam int SCREEN_H = 480;
    localparam int SCREEN_W = 640;

    typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/bird_physics_flap_sync.sv
// Two-flop synchroniser for the asynchronous flap button plus a rising-edge pulse.
module flap_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_flap_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_flap_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/bird_physics.sv
// Bird vertical physics and game FSM, fixed-point position/velocity updated once per frame.
// Define CEIL_KILL_EN to make ceiling contact fatal; otherwise the bird is clamped and keeps playing.
//
// state    | meaning
// IDLE     | waiting for game_start, position frozen at spawn
// PLAY     | gravity and flaps applied on each frame_tick
// DYING    | hit by a pipe, falling under gravity only
// DEAD     | on the floor (or ceiling with kill), frozen until reset
module bird_physics #(
    parameter int          Y_W      = 10,
    parameter int          FRAC_W   = 4,
    parameter int          X_POS    = 200,
    parameter int          SPR_H    = 20,
    parameter int          SPR_W    = 20,
    parameter int          Y_START  = 240,
    parameter int          Y_MIN    = 10,
    parameter int          Y_MAX    = 470,
    parameter int          GRAVITY  = 4,
    parameter int          FLAP_VEL = 64,
    parameter int          VMAX     = 128,
    parameter logic [11:0] COLOR    = 12'hF0F
) (
    input  logic           clk_100MHz,
    input  logic           rst_n,
    input  logic           frame_tick,
    input  logic           flap,
    input  logic           game_start,
    input  logic           lose,
    output logic [Y_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [4:0]     high,
    output logic [4:0]     width,
    output logic [11:0]    bruin_color,
    output logic [1:0]     state,
    output logic           game_over
);
    import flappy_pkg::*;

    localparam int PW = Y_W + FRAC_W;
    localparam int VW = PW + 1;
    localparam int SW = VW + 1;

    localparam logic [PW-1:0]        POS_START = PW'(Y_START << FRAC_W);
    localparam logic [PW-1:0]        POS_MIN   = PW'(Y_MIN << FRAC_W);
    localparam logic [PW-1:0]        POS_MAX   = PW'(Y_MAX << FRAC_W);
    localparam logic signed [SW-1:0] PMIN_S    = SW'(Y_MIN << FRAC_W);
    localparam logic signed [SW-1:0] PMAX_S    = SW'(Y_MAX << FRAC_W);
    localparam logic signed [SW-1:0] GRAV_S    = SW'(GRAVITY);
    localparam logic signed [SW-1:0] VMAX_S    = SW'(VMAX);
    localparam logic signed [SW-1:0] FLAP_S    = SW'(-FLAP_VEL);

`ifdef CEIL_KILL_EN
    localparam bit CEIL_KILL = 1'b1;
`else
    localparam bit CEIL_KILL = 1'b0;
`endif

    bird_state_t           r_state;
    logic [PW-1:0]         r_pos;
    logic signed [VW-1:0]  r_vel;
    logic                  r_flap_pend;
    logic [Y_W-1:0]        r_y;
    logic                  r_game_over;

    logic                  w_flap_rise;
    logic signed [SW-1:0]  w_vel_grav;
    logic signed [SW-1:0]  w_vel_fall;
    logic signed [SW-1:0]  w_vel_next;
    logic signed [SW-1:0]  w_pos_sum;
    logic                  w_floor;
    logic                  w_ceil;
    logic                  w_kill;
    logic [PW-1:0]         w_pos_new;
    logic signed [VW-1:0]  w_vel_new;

    flap_sync u_flap_sync (
        .i_clk        (clk_100MHz),
        .i_rst_n      (rst_n),
        .i_flap_async (flap),
        .o_rise       (w_flap_rise)
    );

    // Sums are one bit wider than velocity so neither clamp can be fooled by wrap-around.
    always_comb begin
        w_vel_grav = SW'(r_vel) + GRAV_S;
        w_vel_fall = (w_vel_grav > VMAX_S) ? VMAX_S : w_vel_grav;
        w_vel_next = (r_state == ST_PLAY && r_flap_pend) ? FLAP_S : w_vel_fall;
        w_pos_sum  = $signed({2'b00, r_pos}) + w_vel_next;
        w_floor    = (w_pos_sum >= PMAX_S);
        w_ceil     = (w_pos_sum <= PMIN_S);
        w_kill     = w_floor | (w_ceil & CEIL_KILL);
        w_pos_new  = PW'(w_pos_sum);
        w_vel_new  = VW'(w_vel_next);
        if (w_floor) begin
            w_pos_new = POS_MAX;
            w_vel_new = '0;
        end else if (w_ceil) begin
            w_pos_new = POS_MIN;
            w_vel_new = '0;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pos       <= POS_START;
            r_vel       <= '0;
            r_flap_pend <= 1'b0;
            r_y         <= Y_W'(Y_START);
            r_game_over <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (game_start)
                        r_state <= ST_PLAY;
                end
                ST_PLAY, ST_DYING: begin
                    if (r_state == ST_PLAY && lose)
                        r_state <= ST_DYING;
                    // A kill on this tick overrides the lose transition above.
                    if (frame_tick) begin
                        r_pos <= w_pos_new;
                        r_vel <= w_vel_new;
                        r_y   <= w_pos_new[PW-1:FRAC_W];
                        if (w_kill) begin
                            r_state     <= ST_DEAD;
                            r_game_over <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (r_state != ST_PLAY)
                r_flap_pend <= 1'b0;
            else if (frame_tick)
                r_flap_pend <= w_flap_rise;
            else if (w_flap_rise)
                r_flap_pend <= 1'b1;
        end
    end

    assign x           = Y_W'(X_POS);
    assign y           = r_y;
    assign high        = 5'(SPR_H);
    assign width       = 5'(SPR_W);
    assign bruin_color = COLOR;
    assign state       = r_state;
    assign game_over   = r_game_over;

endmodule

// File: doc/bird_physics.md
BIRD_PHYSICS -- requirements
Module: bird_physics

Interface
REQ-001 Parameters (name, default, meaning):
  Y_W, 10, integer pixel width of vertical position
  FRAC_W, 4, fractional bits of position/velocity (sub-pixel fixed point)
  X_POS, 200, fixed sprite column
  SPR_H, 20, sprite height in pixels
  SPR_W, 20, sprite width in pixels
  Y_START, 240, spawn row (sprite centre)
  Y_MIN, 10, ceiling row (SPR_H/2)
  Y_MAX, 470, floor row (480 - SPR_H/2)
  GRAVITY, 4, velocity increment per frame, Q(FRAC_W) (0.25 px/frame^2)
  FLAP_VEL, 64, upward velocity set by a flap, Q(FRAC_W) (4 px/frame)
  VMAX, 128, terminal downward velocity, Q(FRAC_W) (8 px/frame)
  COLOR, 12'hF0F, sprite RGB444
REQ-002 Ports (name  direction  width  meaning):
  clk_100MHz  in  1  sole clock
  rst_n  in  1  asynchronous active-low reset
  frame_tick  in  1  one-cycle strobe, once per video frame (60 Hz)
  flap  in  1  raw button level, asynchronous to clk_100MHz
  game_start  in  1  level; enables play
  lose  in  1  one-cycle or level collision indication from pipe logic
  x  out  Y_W  sprite column (X_POS)
  y  out  Y_W  integer part of vertical position
  high  out  5  SPR_H
  width  out  5  SPR_W
  bruin_color  out  12  COLOR
  state  out  2  current FSM state (encoding from package)
  game_over  out  1  high in DEAD
REQ-003 Clock is clk_100MHz only; reset is rst_n, asynchronous assert, active-low.

Function
REQ-004 FSM states IDLE, PLAY, DYING, DEAD; all transitions on clk_100MHz edges.
REQ-005 IDLE -> PLAY on first cycle game_start=1; position/velocity frozen in IDLE.
REQ-006 flap passes a two-flop synchroniser; rising edge sets flap_pend; flap_pend clears on the frame_tick that consumes it; multiple edges between ticks = one flap.
REQ-007 flap edges are ignored (flap_pend not set) outside PLAY.
REQ-008 On frame_tick in PLAY: vel_next = -FLAP_VEL if flap_pend else min(vel+GRAVITY, VMAX); pos_next = pos + vel_next.
REQ-009 Position unsigned Q(Y_W.FRAC_W); velocity signed, Y_W+FRAC_W+1 bits; intermediate sums one bit wider, no wrap-around.
REQ-010 Floor: if pos_next >= Y_MAX, pos = Y_MAX, vel = 0, state -> DEAD, game_over = 1 next cycle.
REQ-011 Ceiling: if pos_next <= Y_MIN, pos = Y_MIN, vel = 0 (see REQ-018).
REQ-012 lose=1 in PLAY -> DYING next cycle; same-cycle frame_tick still applies REQ-008 update first.
REQ-013 DYING: on each frame_tick, gravity only (no flap), floor per REQ-010 -> DEAD.
REQ-014 DEAD: position, velocity frozen; leaves DEAD only by reset.
REQ-015 Floor and lose in same tick: DEAD wins.
REQ-016 y = pos[integer part] registered; x, high, width, bruin_color constant.

Reset
REQ-017 rst_n low (any time, mid-frame included): state IDLE, pos = Y_START.0, vel = 0, flap_pend = 0, synchroniser flops 0, game_over = 0, y = Y_START.

Configuration
REQ-018 CEIL_KILL_EN defined: ceiling contact (REQ-011) clamps pos to Y_MIN and goes to DEAD with game_over=1; undefined: clamp and vel=0, stay in PLAY.

Structure
REQ-019 Package flappy_pkg: FSM state enum, FRAC_W, screen constants (480, 640), RGB444 typedef.
REQ-020 Sub-module flap_sync: two-flop synchroniser plus rising-edge pulse; physics and FSM in bird_physics.

Verification
REQ-021 Reset, game_start=1, 4 ticks, no flap -> y = 240,240,241,242 (pos 240.25, 240.75, 241.5, 242.5).
REQ-022 PLAY at 240.0, vel 0, one flap press then tick -> y=236, vel=-64; 3 flap edges before one tick -> single flap.
REQ-023 Free fall from 240 -> vel saturates at 128, y reaches 470, game_over=1, state DEAD; further ticks and flaps change nothing.
REQ-024 lose pulse at y=236 vel=-64 -> DYING, flaps ignored, gravity continues, ends DEAD at y=470.
REQ-025 Flaps each tick from y=14: CEIL_KILL_EN undefined -> y=10, vel=0, PLAY; defined -> y=10, DEAD, game_over=1.
REQ-026 rst_n low mid-PLAY between clock edges -> outputs immediately y=240, game_over=0, state IDLE.
